// File: rtl/cla_adder_1.sv
// cla_adder_1: 4-bit carry-lookahead adder with registered sum, carry-out and group P/G.
// Carries are flat sum-of-products of per-bit generate/propagate, never rippled.
module cla_adder_1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic       w_gg;
    logic [3:0] r_s;
    logic       r_cout;
    logic       r_pg;
    logic       r_gg;

    assign w_g = a & b;
    assign w_p = a ^ b;
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
    // Group generate excludes cin so an external lookahead unit can cascade slices
    assign w_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_pg   <= 1'b0;
            r_gg   <= 1'b0;
        end else begin
            r_s    <= w_p ^ w_c[3:0];
            r_cout <= w_c[4];
            r_pg   <= &w_p;
            r_gg   <= w_gg;
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign pg   = r_pg;
    assign gg   = r_gg;
endmodule

// File: tb/tb_cla_adder_1.sv
// tb_cla_adder_1: directed and exhaustive self-checking bench for cla_adder_1.
module tb_cla_adder_1;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       pg;
    logic       gg;
    int         errors = 0;
    int         checks = 0;

    cla_adder_1 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .s   (s),
        .cout(cout),
        .pg  (pg),
        .gg  (gg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        a   = ta;
        b   = tb;
        cin = tc;
        @(posedge clk);
        #1;
    endtask

    // Expected {cout,s} and {pg,gg} are hand-computed per vector
    task automatic vec(input string tag, input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic [4:0] exp_sum, input logic [1:0] exp_pgg);
        step(ta, tb, tc);
        check({tag, "_sum"}, {3'b0, cout, s}, {3'b0, exp_sum});
        check({tag, "_pgg"}, {6'b0, pg, gg}, {6'b0, exp_pgg});
    endtask

    initial begin
        rst = 1'b1;
        step(4'hF, 4'hF, 1'b1);
        step(4'hF, 4'hF, 1'b1);
        check("reset", {2'b0, cout, s, pg, gg}, 8'h00);
        rst = 1'b0;
        vec("rel",    4'hF,    4'hF,    1'b1, 5'b11111, 2'b01);
        vec("nc1",    4'b0010, 4'b0100, 1'b0, 5'b00110, 2'b00);
        vec("nc2",    4'b0110, 4'b0101, 1'b0, 5'b01011, 2'b00);
        vec("cz1",    4'b1010, 4'b0110, 1'b0, 5'b10000, 2'b01);
        vec("cz2",    4'b0100, 4'b1100, 1'b0, 5'b10000, 2'b01);
        vec("fp0",    4'b0011, 4'b1100, 1'b0, 5'b01111, 2'b10);
        vec("fp1",    4'b0011, 4'b1100, 1'b1, 5'b10000, 2'b10);
        vec("lg1",    4'b1110, 4'b1101, 1'b0, 5'b11011, 2'b01);
        vec("lg2",    4'b1110, 4'b1111, 1'b0, 5'b11101, 2'b01);
        vec("ci1",    4'b0110, 4'b0101, 1'b1, 5'b01100, 2'b00);
        vec("ci2",    4'b1010, 4'b0110, 1'b1, 5'b10001, 2'b01);
        vec("ci3",    4'b1110, 4'b1101, 1'b1, 5'b11100, 2'b01);
        // Input changes between edges must not reach the registered outputs
        a = 4'h0;
        b = 4'h0;
        cin = 1'b0;
        #3;
        check("hold", {3'b0, cout, s}, 8'h1C);
        // Mid-stream reset discards the in-flight result
        rst = 1'b1;
        step(4'h7, 4'h8, 1'b1);
        check("midrst", {2'b0, cout, s, pg, gg}, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] e_sum;
            logic       e_pg;
            logic       e_gg;
            v     = i[8:0];
            e_sum = {1'b0, v[7:4]} + {1'b0, v[3:0]} + {4'b0, v[8]};
            e_pg  = (v[7:4] ^ v[3:0]) == 4'hF;
            e_gg  = ({1'b0, v[7:4]} + {1'b0, v[3:0]}) > 5'd15;
            step(v[7:4], v[3:0], v[8]);
            check("sw_sum", {3'b0, cout, s}, {3'b0, e_sum});
            check("sw_pgg", {6'b0, pg, gg}, {6'b0, e_pg, e_gg});
            check("sw_cons", {7'b0, cout}, {7'b0, gg | (pg & v[8])});
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
